// File: rtl/lab3_mem_mem_port_arbiter.sv
// Round-robin arbiter that shares one memory request/response port among p_num_reqs requesters.
// Owners of accepted requests go into an in-order FIFO so that each response returns to the right requester.
module lab3_mem_mem_port_arbiter #(
   parameter int p_num_reqs   = 2,
   parameter int p_req_nbits  = 175,
   parameter int p_resp_nbits = 145,
   parameter int p_max_out    = 2
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [p_num_reqs-1:0]                reqs_val,
   output logic [p_num_reqs-1:0]                reqs_rdy,
   input  logic [p_num_reqs*p_req_nbits-1:0]    reqs_msg,
   output logic                                 memreq_val,
   input  logic                                 memreq_rdy,
   output logic [p_req_nbits-1:0]               memreq_msg,
   input  logic                                 memresp_val,
   output logic                                 memresp_rdy,
   input  logic [p_resp_nbits-1:0]              memresp_msg,
   output logic [p_num_reqs-1:0]                resps_val,
   input  logic [p_num_reqs-1:0]                resps_rdy,
   output logic [p_resp_nbits-1:0]              resps_msg,
   output logic [$clog2(p_max_out+1)-1:0]       num_out
);
   localparam int IDX_W = $clog2(p_num_reqs);
   localparam int PTR_W = (p_max_out > 1) ? $clog2(p_max_out) : 1;
   localparam int CNT_W = $clog2(p_max_out + 1);

   logic [IDX_W-1:0] prio_q, prio_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [IDX_W-1:0] owner_mem [p_max_out];

   logic [IDX_W-1:0] grant;
   logic [IDX_W-1:0] head;
   logic             grant_found;
   logic             full;
   logic             empty;
   logic             req_fire;
   logic             resp_fire;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (int'(p) == p_max_out - 1) ? '0 : p + PTR_W'(1);
   endfunction

   // Scan requesters starting at prio, wrapping modulo p_num_reqs.
   always_comb begin
      int idx;
      idx         = 0;
      grant       = '0;
      grant_found = 1'b0;
      for (int k = 0; k < p_num_reqs; k++) begin
         idx = int'(prio_q) + k;
         if (idx >= p_num_reqs) idx = idx - p_num_reqs;
         if (!grant_found && reqs_val[idx]) begin
            grant_found = 1'b1;
            grant       = IDX_W'(idx);
         end
      end
   end

   assign full        = (count_q == CNT_W'(p_max_out));
   assign empty       = (count_q == '0);
   assign memreq_val  = !reset && grant_found && !full;
   assign memreq_msg  = (!reset && grant_found) ? reqs_msg[grant*p_req_nbits +: p_req_nbits] : '0;
   assign req_fire    = memreq_val && memreq_rdy;

   assign head        = owner_mem[rd_ptr_q];
   assign memresp_rdy = !reset && !empty && resps_rdy[head];
   assign resp_fire   = memresp_val && memresp_rdy;
   assign resps_msg   = memresp_msg;
   assign num_out     = count_q;

   generate
      for (genvar gi = 0; gi < p_num_reqs; gi++) begin : g_port
         assign reqs_rdy[gi]  = req_fire && (grant == IDX_W'(gi));
         assign resps_val[gi] = !reset && memresp_val && !empty && (head == IDX_W'(gi));
      end
   endgenerate

   always_comb begin
      prio_d   = prio_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (req_fire) begin
         prio_d   = (int'(grant) == p_num_reqs - 1) ? '0 : grant + IDX_W'(1);
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (resp_fire) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (req_fire && !resp_fire)      count_d = count_q + CNT_W'(1);
      else if (resp_fire && !req_fire) count_d = count_q - CNT_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prio_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         prio_q   <= prio_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Owner storage needs no reset: the count and pointers define which entries are live.
   always_ff @(posedge clk) begin
      if (req_fire) owner_mem[wr_ptr_q] <= grant;
   end

   assert property (@(posedge clk) disable iff (reset) !(memresp_val && empty))
      else $error("memresp_val asserted with no outstanding request");

endmodule

// File: tb/tb_lab3_mem_mem_port_arbiter.sv
// Directed and randomized bench for lab3_mem_mem_port_arbiter, checked against a queue-based owner model.
module tb_lab3_mem_mem_port_arbiter;
   localparam int N    = 2;
   localparam int RQW  = 175;
   localparam int RSW  = 145;
   localparam int MAXO = 2;
   localparam int CW   = $clog2(MAXO + 1);

   logic             clk = 1'b0;
   logic             reset;
   logic [N-1:0]     reqs_val, reqs_rdy, resps_val, resps_rdy;
   logic [N*RQW-1:0] reqs_msg;
   logic             memreq_val, memreq_rdy, memresp_val, memresp_rdy;
   logic [RQW-1:0]   memreq_msg;
   logic [RSW-1:0]   memresp_msg, resps_msg;
   logic [CW-1:0]    num_out;

   int checks = 0;
   int errors = 0;
   int owners[$];
   int prio_m = 0;
   int cyc = 0;
   int cur_g;
   bit cur_rf, cur_sf;
   int last_grant;
   logic [RQW-1:0] m0;

   always #5 clk = ~clk;

   lab3_mem_mem_port_arbiter #(
      .p_num_reqs(N), .p_req_nbits(RQW), .p_resp_nbits(RSW), .p_max_out(MAXO)
   ) dut (
      .clk(clk), .reset(reset),
      .reqs_val(reqs_val), .reqs_rdy(reqs_rdy), .reqs_msg(reqs_msg),
      .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_msg(memreq_msg),
      .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_msg(memresp_msg),
      .resps_val(resps_val), .resps_rdy(resps_rdy), .resps_msg(resps_msg),
      .num_out(num_out)
   );

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int model_grant();
      for (int k = 0; k < N; k++) begin
         int i;
         i = (prio_m + k) % N;
         if (reqs_val[i]) return i;
      end
      return -1;
   endfunction

   task automatic rand_msgs();
      for (int b = 0; b < N*RQW; b++) reqs_msg[b] = 1'($urandom_range(0, 1));
      for (int b = 0; b < RSW; b++) memresp_msg[b] = 1'($urandom_range(0, 1));
   endtask

   task automatic set_idle();
      reqs_val    = '0;
      memreq_rdy  = 1'b1;
      memresp_val = 1'b0;
      resps_rdy   = '1;
   endtask

   // Compare all combinational outputs against the model for the inputs just driven.
   task automatic check_now(input string tag);
      bit             full;
      logic [N-1:0]   e_rdy, e_rv;
      logic [RQW-1:0] e_msg;
      bit             e_mrdy;
      #1;
      cur_g  = model_grant();
      full   = (owners.size() == MAXO);
      e_rdy  = '0;
      e_rv   = '0;
      e_msg  = '0;
      if (cur_g >= 0) begin
         e_msg = reqs_msg[cur_g*RQW +: RQW];
         if (memreq_rdy && !full) e_rdy[cur_g] = 1'b1;
      end
      e_mrdy = (owners.size() > 0) && resps_rdy[owners[0]];
      if (memresp_val && owners.size() > 0) e_rv[owners[0]] = 1'b1;
      chk({tag, "_memreq_val"},  256'(memreq_val),  256'(cur_g >= 0 && !full));
      chk({tag, "_memreq_msg"},  256'(memreq_msg),  256'(e_msg));
      chk({tag, "_reqs_rdy"},    256'(reqs_rdy),    256'(e_rdy));
      chk({tag, "_memresp_rdy"}, 256'(memresp_rdy), 256'(e_mrdy));
      chk({tag, "_resps_val"},   256'(resps_val),   256'(e_rv));
      chk({tag, "_resps_msg"},   256'(resps_msg),   256'(memresp_msg));
      chk({tag, "_num_out"},     256'(num_out),     256'(owners.size()));
      cur_rf = (cur_g >= 0) && !full && memreq_rdy;
      cur_sf = memresp_val && e_mrdy;
   endtask

   task automatic advance();
      @(posedge clk);
      if (cur_sf) begin
         $display("cycle %0d: response to requester %0d msg %0h", cyc, owners[0], memresp_msg);
         void'(owners.pop_front());
      end
      if (cur_rf) begin
         owners.push_back(cur_g);
         prio_m = (cur_g + 1) % N;
         $display("cycle %0d: request granted to %0d msg %0h", cyc, cur_g, reqs_msg[cur_g*RQW +: RQW]);
      end
      last_grant = cur_rf ? cur_g : -1;
      cyc++;
      #1;
   endtask

   task automatic cycle(input string tag);
      check_now(tag);
      advance();
   endtask

   task automatic do_reset(input bit check_outs);
      reset       = 1'b1;
      reqs_val    = '1;
      memreq_rdy  = 1'b1;
      memresp_val = 1'b1;
      resps_rdy   = '1;
      #1;
      if (check_outs) begin
         chk("rst_memreq_val",  256'(memreq_val),  256'(0));
         chk("rst_memreq_msg",  256'(memreq_msg),  256'(0));
         chk("rst_reqs_rdy",    256'(reqs_rdy),    256'(0));
         chk("rst_memresp_rdy", 256'(memresp_rdy), 256'(0));
         chk("rst_resps_val",   256'(resps_val),   256'(0));
         chk("rst_num_out",     256'(num_out),     256'(0));
      end
      owners.delete();
      prio_m = 0;
      set_idle();
      @(posedge clk);
      @(posedge clk);
      #3 reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      reqs_msg = '0;
      memresp_msg = '0;
      do_reset(1'b1);

      // Single requester read to 0x1000, response three cycles later
      m0 = '0;
      m0[159:128] = 32'h0000_1000;
      m0[127:0]   = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
      reqs_msg[0 +: RQW] = m0;
      reqs_val = 2'b01;
      check_now("t1_req");
      chk("t1_msg", 256'(memreq_msg), 256'(m0));
      advance();
      chk("t1_num_out1", 256'(num_out), 256'(1));
      reqs_val = '0;
      cycle("t1_wait");
      cycle("t1_wait");
      memresp_val = 1'b1;
      memresp_msg = {17'h1abcd, 128'hcafe_f00d_0000_1111_2222_3333_4444_5555};
      check_now("t1_resp");
      chk("t1_resps_val", 256'(resps_val), 256'(2'b01));
      advance();
      memresp_val = 1'b0;
      chk("t1_num_out0", 256'(num_out), 256'(0));

      // Both requesters always valid, prompt responses: grants alternate
      do_reset(1'b0);
      reqs_val = 2'b11;
      for (int k = 0; k < 8; k++) begin
         rand_msgs();
         memresp_val = (owners.size() > 0);
         cycle("t2");
         chk("t2_grant", 256'(last_grant), 256'(k % 2));
      end

      // Fill to p_max_out with responses withheld
      do_reset(1'b0);
      reqs_val = 2'b11;
      cycle("t3_fill");
      cycle("t3_fill");
      check_now("t3_full");
      chk("t3_full_rdy", 256'(reqs_rdy), 256'(0));
      chk("t3_full_val", 256'(memreq_val), 256'(0));
      advance();
      memresp_val = 1'b1;
      check_now("t3_pop");
      chk("t3_pop_noreq", 256'(memreq_val), 256'(0));
      advance();
      memresp_val = 1'b0;
      check_now("t3_after");
      chk("t3_after_rdy", 256'(reqs_rdy), 256'(2'b01));
      advance();
      reqs_val = '0;
      for (int k = 0; k < 4; k++) begin
         memresp_val = (owners.size() > 0);
         cycle("t3_drain");
      end

      // Response backpressure on owner 1 blocks owner 0's later response
      do_reset(1'b0);
      reqs_val = 2'b10;
      cycle("t4_req1");
      reqs_val = 2'b01;
      cycle("t4_req0");
      reqs_val = '0;
      memresp_val = 1'b1;
      resps_rdy = 2'b01;
      for (int k = 0; k < 3; k++) begin
         check_now("t4_stall");
         chk("t4_stall_rdy", 256'(memresp_rdy), 256'(0));
         chk("t4_stall_val", 256'(resps_val), 256'(2'b10));
         advance();
      end
      resps_rdy = 2'b11;
      check_now("t4_drain1");
      chk("t4_owner1", 256'(resps_val), 256'(2'b10));
      advance();
      check_now("t4_drain0");
      chk("t4_owner0", 256'(resps_val), 256'(2'b01));
      advance();
      memresp_val = 1'b0;

      // memreq_rdy stall with prio=1 holds the grant on requester 1
      do_reset(1'b0);
      reqs_val = 2'b01;
      cycle("t5_setup");
      reqs_val = '0;
      memresp_val = 1'b1;
      cycle("t5_setup_resp");
      memresp_val = 1'b0;
      rand_msgs();
      reqs_val = 2'b11;
      memreq_rdy = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check_now("t5_stall");
         chk("t5_stall_rdy", 256'(reqs_rdy), 256'(0));
         chk("t5_stall_msg", 256'(memreq_msg), 256'(reqs_msg[RQW +: RQW]));
         advance();
      end
      memreq_rdy = 1'b1;
      check_now("t5_fire");
      chk("t5_fire_rdy", 256'(reqs_rdy), 256'(2'b10));
      advance();
      check_now("t5_next");
      chk("t5_next_rdy", 256'(reqs_rdy), 256'(2'b01));
      advance();
      set_idle();
      for (int k = 0; k < 4; k++) begin
         memresp_val = (owners.size() > 0);
         cycle("t5_drain");
      end

      // Reset mid-clock with one request outstanding
      do_reset(1'b0);
      reqs_val = 2'b01;
      cycle("t6_req");
      chk("t6_num_out1", 256'(num_out), 256'(1));
      reqs_val = 2'b11;
      #2;
      do_reset(1'b1);
      memresp_val = 1'b1;
      #1;
      chk("t6_stray_rdy", 256'(memresp_rdy), 256'(0));
      chk("t6_stray_val", 256'(resps_val), 256'(0));
      chk("t6_num_out0", 256'(num_out), 256'(0));
      memresp_val = 1'b0;
      @(posedge clk);
      #1;
      reqs_val = 2'b11;
      check_now("t6_prio");
      chk("t6_prio0", 256'(reqs_rdy), 256'(2'b01));
      advance();

      // Randomized traffic
      do_reset(1'b0);
      for (int k = 0; k < 300; k++) begin
         rand_msgs();
         reqs_val    = N'($urandom_range(0, (1 << N) - 1));
         memreq_rdy  = ($urandom_range(0, 3) != 0);
         resps_rdy   = N'($urandom_range(0, (1 << N) - 1));
         memresp_val = (owners.size() > 0) && ($urandom_range(0, 1) == 1);
         cycle("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
